// File: rtl/rt_vc_buffer_pkg.sv
// Shared router defaults and the VC-tagged flit type used by the per-port input buffers.
package rt_vc_buffer_pkg;

    localparam int RT_DEFAULT_WIDTH = 512;
    localparam int RT_DEFAULT_VCS   = 2;
    localparam int RT_DEFAULT_VCW   = (RT_DEFAULT_VCS > 1) ? $clog2(RT_DEFAULT_VCS) : 1;

    typedef struct packed {
        logic [RT_DEFAULT_VCW-1:0]   vc;
        logic [RT_DEFAULT_WIDTH-1:0] data;
    } rt_vc_flit_t;

endpackage

// File: rtl/rt_vc_fifo.sv
// Single-VC circular FIFO; the head entry is readable combinationally, push/pop take effect on the edge.
// Caller must not push when full or pop when empty; full/empty reflect the count at cycle start.
module rt_vc_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rt_vc_buffer.sv
// Per-port input buffer: NUM_VC FIFOs drained round-robin into one registered req/ack output stage.
// Flit reaches out_req one edge after it is pushed; in_ack drops per VC when that FIFO is full.
module rt_vc_buffer
    import rt_vc_buffer_pkg::*;
#(
    parameter int WIDTH  = RT_DEFAULT_WIDTH,
    parameter int DEPTH  = 4,
    parameter int NUM_VC = RT_DEFAULT_VCS,
    parameter int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_req,
    input  logic [VCW-1:0]       in_vc,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ack,
    output logic                 out_req,
    output logic [VCW-1:0]       out_vc,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ack,
    output logic [NUM_VC*CW-1:0] vc_count,
    output logic                 err_vc
);

    localparam logic [VCW:0] NVC = (VCW + 1)'(NUM_VC);

    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    logic [WIDTH-1:0]  head [NUM_VC];
    logic [CW-1:0]     cnt  [NUM_VC];

    logic              vc_ok;
    logic              load;
    logic              any_data;
    logic              do_pop;
    logic [VCW-1:0]    win;
    logic [VCW-1:0]    rr_last;

    assign vc_ok    = ({1'b0, in_vc} < NVC);
    assign in_ack   = rst_n && vc_ok && !full[in_vc];
    assign any_data = ~(&empty);
    assign load     = !out_req || out_ack;
    assign do_pop   = load && any_data;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign push[v] = in_req && in_ack && (in_vc == VCW'(v));
        assign pop[v]  = do_pop && (win == VCW'(v));
        assign vc_count[v*CW +: CW] = cnt[v];

        rt_vc_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[v]),
            .push_data (in_data),
            .pop       (pop[v]),
            .pop_data  (head[v]),
            .full      (full[v]),
            .empty     (empty[v]),
            .count     (cnt[v])
        );
    end

    // Round-robin: first non-empty VC after the last one served.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (int'(rr_last) + 1 + i) % NUM_VC;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                win   = VCW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_req  <= 1'b0;
            out_vc   <= '0;
            out_data <= '0;
            rr_last  <= VCW'(NUM_VC - 1);
            err_vc   <= 1'b0;
        end else begin
            if (in_req && !vc_ok) begin
                err_vc <= 1'b1;
            end
            if (load) begin
                if (any_data) begin
                    out_req  <= 1'b1;
                    out_vc   <= win;
                    out_data <= head[win];
                    rr_last  <= win;
                end else begin
                    out_req  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rt_vc_buffer.sv
// Directed checks of rt_vc_buffer: two-VC instance for flow/arbitration, three-VC instance for illegal ids.
module tb_rt_vc_buffer;

    localparam int W  = 16;
    localparam int D  = 4;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         in_req, in_ack, out_req, out_ack, err_vc;
    logic [0:0]   in_vc, out_vc;
    logic [W-1:0] in_data, out_data;
    logic [5:0]   vc_count;

    logic         in_req3, in_ack3, out_req3, out_ack3, err_vc3;
    logic [1:0]   in_vc3, out_vc3;
    logic [W-1:0] in_data3, out_data3;
    logic [8:0]   vc_count3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rt_vc_buffer #(.WIDTH(W), .DEPTH(D), .NUM_VC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_req(in_req), .in_vc(in_vc), .in_data(in_data), .in_ack(in_ack),
        .out_req(out_req), .out_vc(out_vc), .out_data(out_data), .out_ack(out_ack),
        .vc_count(vc_count), .err_vc(err_vc)
    );

    rt_vc_buffer #(.WIDTH(W), .DEPTH(D), .NUM_VC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_req(in_req3), .in_vc(in_vc3), .in_data(in_data3), .in_ack(in_ack3),
        .out_req(out_req3), .out_vc(out_vc3), .out_data(out_data3), .out_ack(out_ack3),
        .vc_count(vc_count3), .err_vc(err_vc3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_req = 1'b1; in_vc = 1'b0; in_data = 16'h1234; out_ack = 1'b0;
        in_req3 = 1'b0; in_vc3 = 2'd0; in_data3 = '0; out_ack3 = 1'b0;
        #2;
        total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL reset_in_ack got=%b exp=0", in_ack); end
        tick(); tick();
        total++; if (out_req !== 1'b0) begin bad++; $display("FAIL reset_out_req got=%b exp=0", out_req); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (vc_count !== 6'd0) begin bad++; $display("FAIL reset_vc_count got=%h exp=0", vc_count); end
        total++; if (err_vc !== 1'b0) begin bad++; $display("FAIL reset_err_vc got=%b exp=0", err_vc); end
        total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL reset_in_ack_held got=%b exp=0", in_ack); end
        in_req = 1'b0;
    endtask

    task automatic test_single();
        rst_n = 1'b1; in_req = 1'b1; in_vc = 1'b0; in_data = 16'h00A5; out_ack = 1'b0;
        #1;
        total++; if (in_ack !== 1'b1) begin bad++; $display("FAIL single_in_ack got=%b exp=1", in_ack); end
        tick();
        in_req = 1'b0;
        total++; if (out_req !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b exp=0", out_req); end
        total++; if (vc_count[2:0] !== 3'd1) begin bad++; $display("FAIL single_cnt0 got=%0d exp=1", vc_count[2:0]); end
        tick();
        total++; if (out_req !== 1'b1) begin bad++; $display("FAIL single_out_req got=%b exp=1", out_req); end
        total++; if (out_data !== 16'h00A5) begin bad++; $display("FAIL single_out_data got=%h exp=00a5", out_data); end
        total++; if (out_vc !== 1'b0) begin bad++; $display("FAIL single_out_vc got=%b exp=0", out_vc); end
        total++; if (vc_count !== 6'd0) begin bad++; $display("FAIL single_cnt_after got=%h exp=0", vc_count); end
        tick(); tick();
        total++; if (out_req !== 1'b1 || out_data !== 16'h00A5) begin bad++; $display("FAIL single_hold got=%b/%h exp=1/00a5", out_req, out_data); end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        total++; if (out_req !== 1'b0) begin bad++; $display("FAIL single_release got=%b exp=0", out_req); end
    endtask

    task automatic test_fill_vc1();
        in_vc = 1'b1; out_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_req = 1'b1; in_data = W'(i);
            #1;
            total++; if (in_ack !== 1'b1) begin bad++; $display("FAIL fill_ack%0d got=%b exp=1", i, in_ack); end
            tick();
        end
        total++; if (out_req !== 1'b1 || out_data !== 16'd1 || out_vc !== 1'b1) begin bad++; $display("FAIL fill_out got=%b/%h/%b exp=1/0001/1", out_req, out_data, out_vc); end
        total++; if (vc_count[5:3] !== 3'd3) begin bad++; $display("FAIL fill_cnt3 got=%0d exp=3", vc_count[5:3]); end
        in_data = 16'd5;
        #1;
        total++; if (in_ack !== 1'b1) begin bad++; $display("FAIL fill_ack5 got=%b exp=1", in_ack); end
        tick();
        total++; if (vc_count[5:3] !== 3'd4) begin bad++; $display("FAIL fill_cnt4 got=%0d exp=4", vc_count[5:3]); end
        in_data = 16'd6;
        #1;
        total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL fill_full_ack got=%b exp=0", in_ack); end
        tick();
        total++; if (in_ack !== 1'b0 || vc_count[5:3] !== 3'd4) begin bad++; $display("FAIL fill_stall got=%b/%0d exp=0/4", in_ack, vc_count[5:3]); end
        total++; if (out_data !== 16'd1) begin bad++; $display("FAIL fill_out_held got=%h exp=0001", out_data); end
        in_req = 1'b0; out_ack = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            total++; if (out_req !== 1'b1 || out_data !== W'(k)) begin bad++; $display("FAIL drain%0d got=%b/%h exp=1/%h", k, out_req, out_data, W'(k)); end
        end
        tick();
        out_ack = 1'b0;
        total++; if (out_req !== 1'b0 || vc_count !== 6'd0) begin bad++; $display("FAIL drain_empty got=%b/%h exp=0/0", out_req, vc_count); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] pre_d [4];
        logic         pre_v [4];
        logic [W-1:0] exp_d [3];
        pre_d[0] = 16'd10; pre_v[0] = 1'b0;
        pre_d[1] = 16'd11; pre_v[1] = 1'b0;
        pre_d[2] = 16'd20; pre_v[2] = 1'b1;
        pre_d[3] = 16'd21; pre_v[3] = 1'b1;
        exp_d[0] = 16'd20; exp_d[1] = 16'd11; exp_d[2] = 16'd21;
        out_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_req = 1'b1; in_vc = pre_v[i]; in_data = pre_d[i];
            tick();
        end
        in_req = 1'b0;
        total++; if (out_data !== 16'd10 || out_vc !== 1'b0) begin bad++; $display("FAIL rr_first got=%0d/%b exp=10/0", out_data, out_vc); end
        out_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_req !== 1'b1 || out_data !== exp_d[i]) begin bad++; $display("FAIL rr_order%0d got=%b/%0d exp=1/%0d", i, out_req, out_data, exp_d[i]); end
        end
        tick();
        out_ack = 1'b0;
        total++; if (out_req !== 1'b0) begin bad++; $display("FAIL rr_empty got=%b exp=0", out_req); end
    endtask

    task automatic test_full_push_pop();
        out_ack = 1'b0; in_vc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_req = 1'b1; in_data = W'(16'h30 + i);
            tick();
        end
        total++; if (vc_count[2:0] !== 3'd4 || out_data !== 16'h30) begin bad++; $display("FAIL fpp_pre got=%0d/%h exp=4/0030", vc_count[2:0], out_data); end
        in_data = 16'h35; out_ack = 1'b1;
        #1;
        total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL fpp_no_fallthru got=%b exp=0", in_ack); end
        tick();
        total++; if (vc_count[2:0] !== 3'd3 || out_data !== 16'h31) begin bad++; $display("FAIL fpp_pop got=%0d/%h exp=3/0031", vc_count[2:0], out_data); end
        total++; if (in_ack !== 1'b1) begin bad++; $display("FAIL fpp_ack got=%b exp=1", in_ack); end
        tick();
        in_req = 1'b0;
        total++; if (vc_count[2:0] !== 3'd3 || out_data !== 16'h32) begin bad++; $display("FAIL fpp_pushpop got=%0d/%h exp=3/0032", vc_count[2:0], out_data); end
        tick(); tick(); tick();
        total++; if (out_req !== 1'b1 || out_data !== 16'h35) begin bad++; $display("FAIL fpp_last got=%b/%h exp=1/0035", out_req, out_data); end
        tick();
        out_ack = 1'b0;
        total++; if (out_req !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b exp=0", out_req); end
    endtask

    task automatic test_illegal_vc();
        in_req3 = 1'b1; in_vc3 = 2'd3; in_data3 = 16'h00EE;
        #1;
        total++; if (in_ack3 !== 1'b0 || err_vc3 !== 1'b0) begin bad++; $display("FAIL ill_ack got=%b/%b exp=0/0", in_ack3, err_vc3); end
        tick();
        total++; if (err_vc3 !== 1'b1 || vc_count3 !== 9'd0) begin bad++; $display("FAIL ill_err got=%b/%h exp=1/0", err_vc3, vc_count3); end
        in_req3 = 1'b0;
        tick(); tick();
        total++; if (err_vc3 !== 1'b1 || out_req3 !== 1'b0) begin bad++; $display("FAIL ill_sticky got=%b/%b exp=1/0", err_vc3, out_req3); end
        in_req3 = 1'b1; in_vc3 = 2'd2; in_data3 = 16'h0077;
        #1;
        total++; if (in_ack3 !== 1'b1) begin bad++; $display("FAIL vc2_ack got=%b exp=1", in_ack3); end
        tick();
        in_req3 = 1'b0;
        total++; if (vc_count3[8:6] !== 3'd1) begin bad++; $display("FAIL vc2_cnt got=%0d exp=1", vc_count3[8:6]); end
        tick();
        total++; if (out_req3 !== 1'b1 || out_vc3 !== 2'd2 || out_data3 !== 16'h0077) begin bad++; $display("FAIL vc2_out got=%b/%0d/%h exp=1/2/0077", out_req3, out_vc3, out_data3); end
    endtask

    task automatic test_reset_mid();
        out_ack = 1'b0; in_vc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_req = 1'b1; in_data = W'(16'h41 + i);
            tick();
        end
        total++; if (out_req !== 1'b1 || vc_count[5:3] !== 3'd2) begin bad++; $display("FAIL rmid_pre got=%b/%0d exp=1/2", out_req, vc_count[5:3]); end
        rst_n = 1'b0; in_vc = 1'b0; in_data = 16'h0099;
        #1;
        total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack got=%b exp=0", in_ack); end
        tick();
        rst_n = 1'b1; in_req = 1'b0;
        total++; if (out_req !== 1'b0 || out_data !== 16'h0 || out_vc !== 1'b0) begin bad++; $display("FAIL rmid_out got=%b/%h/%b exp=0/0/0", out_req, out_data, out_vc); end
        total++; if (vc_count !== 6'd0 || vc_count3 !== 9'd0) begin bad++; $display("FAIL rmid_cnt got=%h/%h exp=0/0", vc_count, vc_count3); end
        total++; if (err_vc3 !== 1'b0 || out_req3 !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b/%b exp=0/0", err_vc3, out_req3); end
        in_req = 1'b1; in_vc = 1'b0; in_data = 16'h0050;
        tick();
        in_vc = 1'b1; in_data = 16'h0061;
        tick();
        in_req = 1'b0;
        total++; if (out_req !== 1'b1 || out_vc !== 1'b0 || out_data !== 16'h0050) begin bad++; $display("FAIL rmid_first got=%b/%b/%h exp=1/0/0050", out_req, out_vc, out_data); end
        out_ack = 1'b1;
        tick();
        total++; if (out_vc !== 1'b1 || out_data !== 16'h0061) begin bad++; $display("FAIL rmid_second got=%b/%h exp=1/0061", out_vc, out_data); end
        tick();
        out_ack = 1'b0;
        total++; if (out_req !== 1'b0) begin bad++; $display("FAIL rmid_empty got=%b exp=0", out_req); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_vc1();
        test_round_robin();
        test_full_push_pop();
        test_illegal_vc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rt_vc_buffer.md
Name: rt_vc_buffer

Overview:
Parametrised input buffer for one router port, successor to the single-channel req/ack port.
- Accepts flits tagged with a virtual channel (VC) id into NUM_VC independent FIFOs of DEPTH entries each.
- Drains them through a round-robin arbiter into one registered req/ack output stage.
- Sits between a link's RTPort Input side and the router crossbar; instantiated once per port of any router_type.

Parameters:
- WIDTH, 512, flit data width in bits.
- DEPTH, 4, entries per VC FIFO; power of two, >= 2.
- NUM_VC, 2, number of virtual channels; >= 1.
- VCW, (NUM_VC>1 ? $clog2(NUM_VC) : 1), VC id width; derived, not overridden.
- CW, $clog2(DEPTH+1), occupancy counter width; derived.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_req  input  1  upstream flit offered.
- in_vc  input  VCW  target VC of offered flit.
- in_data  input  WIDTH  offered flit.
- in_ack  output  1  flit accepted this cycle.
- out_req  output  1  output register holds a valid flit.
- out_vc  output  VCW  VC of the flit in the output register.
- out_data  output  WIDTH  flit in the output register.
- out_ack  input  1  downstream accepts the output flit this cycle.
- vc_count  output  NUM_VC*CW  per-VC occupancy, VC0 in the LSBs; output register not counted.
- err_vc  output  1  sticky flag: in_req with in_vc >= NUM_VC was seen.

Behaviour:
- Handshake, both sides: a transfer occurs on a rising edge where req && ack == 1.
  - req, vc and data must hold stable until acked.
  - out_req never deasserts without out_ack.
- in_ack is combinational: in_ack = rst_n && in_vc < NUM_VC && count[in_vc] != DEPTH.
  - Full status is taken at cycle start; a same-cycle pop does not free a slot for a same-cycle push (no fall-through).
- Illegal in_vc: the flit is not acked, err_vc sets on the next edge, and err_vc clears only on reset.
- Push: the flit is written at wr_ptr[in_vc], the pointer wraps modulo DEPTH, and the count increments.
- Output stage load condition: (out_req == 0) || (out_ack == 1), and at least one VC non-empty.
  - On load, the arbiter winner's head entry is popped into out_data/out_vc, out_req = 1, and the winner's count decrements.
  - If the load condition holds and all VCs are empty, out_req clears to 0.
  - Back-to-back: with continuous out_ack and data available, one flit per cycle.
- Same-VC push and pop in one cycle: count is unchanged and both pointers advance.
- Arbiter is round-robin.
  - Search starts at (rr_last+1) mod NUM_VC and picks the first non-empty VC.
  - rr_last is updated to the winner only when a pop occurs.
- Latency: a flit pushed on edge k into an empty buffer with an idle output appears with out_req = 1 after edge k+1. There is no bypass path.
- Ordering: FIFO order within a VC; no ordering guarantee across VCs.
- Reset (rst_n = 0 sampled on an edge, including mid-transfer):
  - All counts = 0, pointers = 0, rr_last = NUM_VC-1 (VC0 served first).
  - out_req = 0, out_vc = 0, out_data = 0, err_vc = 0.
  - in_ack = 0 while rst_n = 0; all in-flight flits are discarded.
- FIFO storage contents are not reset.

Decomposition:
- router_pkg additions:
  - RT_DEFAULT_WIDTH = 512 and RT_DEFAULT_VCS = 2.
  - Typedef rt_vc_flit_t (struct of vc and data), parametrised via package localparams for the defaults.
- Sub-module rt_vc_fifo: single-VC circular FIFO with push/pop/full/empty/count.
  - Instantiated NUM_VC times.
  - Arbiter and output register stay in rt_vc_buffer.

Test Plan:
- Reset then single flit: in_req=1, in_vc=0, in_data=0xA5, out_ack=0 → in_ack=1 on cycle 0; out_req=1, out_data=0xA5, out_vc=0 after the next edge, held until out_ack.
- Fill VC1 (DEPTH=4), out_ack=0: four flits 1..4 accepted, output register takes 1, vc_count[1]=3. Keep pushing: fifth flit 5 accepted, vc_count[1]=4; sixth flit sees in_ack=0 and stays stalled.
- Round robin: preload VC0={10,11} and VC1={20,21}, then out_ack=1 continuously → output order 10,20,11,21, one per cycle.
- Push/pop same VC at full: VC0 count=4 and out_ack=1 with an in_req to VC0 → in_ack=0 that cycle, count becomes 3; next cycle push accepted.
- Illegal VC: NUM_VC=3, in_vc=3 → in_ack=0, err_vc=1 after the edge and stays 1 until rst_n=0.
- Reset mid-traffic: rst_n=0 for one edge while out_req=1 and counts are non-zero → out_req=0, all vc_count=0. After release, the first pushed flit is served from VC0 first.
